// File: rtl/j_count_pkg.sv
// Shared definitions for the j_count_n Johnson/serial counter family:
// mode encodings and the helper that sizes the step index output.
package j_count_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    // Number of bits needed to index every position of a 2*width Johnson cycle.
    function automatic int step_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/j_count_decode.sv
// Combinational decode of a Johnson counter state into its cycle position
// (step) and a flag telling whether the state is one of the 2*WIDTH legal codes.
module j_count_decode
    import j_count_pkg::*;
#(
    parameter int   WIDTH = 4,
    localparam int  SW    = step_width(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    output logic [SW-1:0]    step,
    output logic             valid
);

    // 2*WIDTH taken modulo 2**SW; subtracting from it modulo 2**SW yields
    // exactly 2*WIDTH - ones because the result always lies in 0..2*WIDTH-1.
    localparam logic [SW-1:0] TWO_W = SW'(2 * WIDTH);

    logic [SW-1:0]    ones;
    logic [WIDTH-1:0] q_inv;

    // Step is the popcount on the filling half and 2*WIDTH minus it on the draining half.
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + {{(SW-1){1'b0}}, q[i]};
        end
        step = q[WIDTH-1] ? (TWO_W - ones) : ones;
    end

    // Legal codes are a run of ones from bit 0 or a run of ones from the MSB;
    // a value of the form 2**k-1 is the only one for which x & (x+1) is zero.
    always_comb begin
        q_inv = ~q;
        valid = ((q & (q + WIDTH'(1))) == '0) ||
                ((q_inv & (q_inv + WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/j_count_n.sv
// WIDTH-bit Johnson up/down counter with serial shift, parallel load and hold,
// a step index, a cycle wrap pulse and illegal-state detection.
// Optional build macro J_COUNT_SELF_CORRECT_EN: when defined, an illegal state
// seen while counting up or down is forced back to zero and flagged on err.
module j_count_n
    import j_count_pkg::*;
#(
    parameter int   WIDTH = 4,
    localparam int  SW    = step_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             din,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [SW-1:0]    step,
    output logic             valid,
    output logic             wrap,
    output logic             err
);

    // The last code of the cycle (step 2*WIDTH-1); up from here, or down into
    // here from zero, is the cycle wrap.
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    j_count_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .q     (q_q),
        .step  (step),
        .valid (valid)
    );

    // Next-state selection: load beats enable, enable beats mode.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                    wrap_d = (q_q == MSB_ONLY);
`ifdef J_COUNT_SELF_CORRECT_EN
                    if (!valid) begin
                        q_d    = '0;
                        wrap_d = 1'b0;
                        err_d  = 1'b1;
                    end
`endif
                end
                MODE_DOWN: begin
                    q_d    = {~q_q[0], q_q[WIDTH-1:1]};
                    wrap_d = (q_q == '0);
`ifdef J_COUNT_SELF_CORRECT_EN
                    if (!valid) begin
                        q_d    = '0;
                        wrap_d = 1'b0;
                        err_d  = 1'b1;
                    end
`endif
                end
                MODE_SHIFT: begin
                    q_d = {q_q[WIDTH-2:0], din};
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    // State and pulse registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_j_count_n.sv
// Self-checking bench for j_count_n: a WIDTH=4 and a WIDTH=2 instance share
// stimulus; a cycle model built from the legal code table checks both every
// cycle, and directed literal expectations pin the model.
module tb_j_count_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       din;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] q4;
    logic [2:0] step4;
    logic       valid4, wrap4, err4;
    logic [1:0] q2;
    logic [1:0] step2;
    logic       valid2, wrap2, err2;

    int checks = 0;
    int errors = 0;

    int m4 = 0, mw4 = 0, me4 = 0;
    int m2 = 0, mw2 = 0, me2 = 0;

    int upQ[9]    = '{1, 3, 7, 15, 14, 12, 8, 0, 1};
    int upStep[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int upQ2[4]   = '{1, 3, 2, 0};
    int shDin[6]  = '{1, 1, 0, 1, 0, 0};
    int shQ[6]    = '{1, 3, 6, 13, 10, 4};
    int shVal[6]  = '{1, 1, 0, 0, 0, 0};

    j_count_n #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .din      (din),
        .load     (load),
        .load_val (load_val),
        .Q        (q4),
        .step     (step4),
        .valid    (valid4),
        .wrap     (wrap4),
        .err      (err4)
    );

    j_count_n #(.WIDTH(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .din      (din),
        .load     (load),
        .load_val (load_val[1:0]),
        .Q        (q2),
        .step     (step2),
        .valid    (valid2),
        .wrap     (wrap2),
        .err      (err2)
    );

    always #5 clk = ~clk;

    // k-th code of a w-bit Johnson cycle: fill ones from bit 0, then drain them.
    function automatic int code_of(input int w, input int k);
        if (k <= w) return (1 << k) - 1;
        return ((1 << w) - 1) & ~((1 << (k - w)) - 1);
    endfunction

    // Position of q in the legal cycle, or -1 if q is not a legal code.
    function automatic int index_of(input int w, input int q);
        for (int k = 0; k < 2 * w; k++) begin
            if (code_of(w, k) == q) return k;
        end
        return -1;
    endfunction

    task automatic modelNext(input int w, input int q, output int nq, output int nw, output int ne);
        int mask;
        int k;
        mask = (1 << w) - 1;
        k    = index_of(w, q);
        nq = q;
        nw = 0;
        ne = 0;
        if (load) begin
            nq = load_val & mask;
        end else if (en) begin
            case (mode)
                2'b01: begin
                    if (k < 0) begin
`ifdef J_COUNT_SELF_CORRECT_EN
                        nq = 0;
                        ne = 1;
`else
                        nq = ((q << 1) | (((q >> (w - 1)) & 1) ^ 1)) & mask;
`endif
                    end else begin
                        nq = code_of(w, (k + 1) % (2 * w));
                        nw = (k == 2 * w - 1) ? 1 : 0;
                    end
                end
                2'b10: begin
                    if (k < 0) begin
`ifdef J_COUNT_SELF_CORRECT_EN
                        nq = 0;
                        ne = 1;
`else
                        nq = (q >> 1) | (((q & 1) ^ 1) << (w - 1));
`endif
                    end else begin
                        nq = code_of(w, (k + 2 * w - 1) % (2 * w));
                        nw = (k == 0) ? 1 : 0;
                    end
                end
                2'b11: nq = ((q << 1) | int'(din)) & mask;
                default: nq = q;
            endcase
        end
    endtask

    always @(posedge clk or posedge reset) begin : model
        int nq, nw, ne;
        if (reset) begin
            m4 <= 0; mw4 <= 0; me4 <= 0;
            m2 <= 0; mw2 <= 0; me2 <= 0;
        end else begin
            modelNext(4, m4, nq, nw, ne);
            m4 <= nq; mw4 <= nw; me4 <= ne;
            modelNext(2, m2, nq, nw, ne);
            m2 <= nq; mw2 <= nw; me2 <= ne;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0d expected=%0d", name, $time, actual, expected);
        end
    endtask

    task automatic compareAll();
        int k4, k2;
        k4 = index_of(4, m4);
        k2 = index_of(2, m2);
        checkOutput("model Q4", int'(q4), m4);
        checkOutput("model valid4", int'(valid4), (k4 >= 0) ? 1 : 0);
        if (k4 >= 0) checkOutput("model step4", int'(step4), k4);
        checkOutput("model wrap4", int'(wrap4), mw4);
        checkOutput("model err4", int'(err4), me4);
        checkOutput("model Q2", int'(q2), m2);
        checkOutput("model valid2", int'(valid2), (k2 >= 0) ? 1 : 0);
        if (k2 >= 0) checkOutput("model step2", int'(step2), k2);
        checkOutput("model wrap2", int'(wrap2), mw2);
        checkOutput("model err2", int'(err2), me2);
    endtask

    always @(posedge clk) begin
        #2;
        compareAll();
    end

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic d,
                                 input logic l, input logic [3:0] lv);
        @(negedge clk);
        en = e; mode = m; din = d; load = l; load_val = lv;
        @(posedge clk);
        #3;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        en = 1'b0; mode = 2'b00; load = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0; en = 1'b0; mode = 2'b00; din = 1'b0; load = 1'b0; load_val = 4'h0;
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("reset Q", int'(q4), 0);
        checkOutput("reset step", int'(step4), 0);
        checkOutput("reset valid", int'(valid4), 1);
        checkOutput("reset wrap", int'(wrap4), 0);
        checkOutput("reset err", int'(err4), 0);
        @(negedge clk) reset = 1'b0;

        $display("[TB] counting up");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
            checkOutput("up Q", int'(q4), upQ[i]);
            checkOutput("up step", int'(step4), upStep[i]);
            checkOutput("up wrap", int'(wrap4), (i == 7) ? 1 : 0);
            if (i < 4) begin
                checkOutput("w2 up Q", int'(q2), upQ2[i]);
                checkOutput("w2 up wrap", int'(wrap2), (i == 3) ? 1 : 0);
            end
        end

        $display("[TB] counting down from reset");
        pulseReset();
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
        checkOutput("down Q", int'(q4), 8);
        checkOutput("down step", int'(step4), 7);
        checkOutput("down wrap", int'(wrap4), 1);
        checkOutput("w2 down Q", int'(q2), 2);
        checkOutput("w2 down wrap", int'(wrap2), 1);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
        checkOutput("down Q", int'(q4), 12);
        checkOutput("down step", int'(step4), 6);
        checkOutput("down wrap", int'(wrap4), 0);

        $display("[TB] serial shift");
        pulseReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'b11, shDin[i][0], 1'b0, 4'h0);
            checkOutput("shift Q", int'(q4), shQ[i]);
            checkOutput("shift valid", int'(valid4), shVal[i]);
            checkOutput("shift err", int'(err4), 0);
        end

        $display("[TB] illegal load then count");
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 4'b0101);
        checkOutput("load Q", int'(q4), 5);
        checkOutput("load valid", int'(valid4), 0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
`ifdef J_COUNT_SELF_CORRECT_EN
        checkOutput("correct Q", int'(q4), 0);
        checkOutput("correct err", int'(err4), 1);
`else
        checkOutput("illegal up Q", int'(q4), 11);
        checkOutput("illegal up err", int'(err4), 0);
`endif
        checkOutput("illegal up wrap", int'(wrap4), 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
        checkOutput("hold err", int'(err4), 0);

        $display("[TB] enable low and asynchronous reset");
        pulseReset();
        repeat (3) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
        checkOutput("pre-hold Q", int'(q4), 7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 4'h0);
            checkOutput("en0 Q", int'(q4), 7);
            checkOutput("en0 wrap", int'(wrap4), 0);
            checkOutput("en0 err", int'(err4), 0);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset Q", int'(q4), 0);
        checkOutput("async reset valid", int'(valid4), 1);
        @(negedge clk) reset = 1'b0;
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 4'b1110);
        checkOutput("load en0 Q", int'(q4), 14);
        checkOutput("load en0 step", int'(step4), 5);
        repeat (3) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
        checkOutput("wrap again Q", int'(q4), 0);
        checkOutput("wrap again", int'(wrap4), 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset wrap", int'(wrap4), 0);
        @(negedge clk) reset = 1'b0;

        $display("[TB] mixed mode sequence");
        for (int i = 0; i < 40; i++) begin
            applyStimulus((i % 7) != 3, 2'((i * 5 + i / 4) % 4), 1'((i * 3) % 5 == 1),
                          (i % 13) == 6, 4'((i * 11) % 16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
